// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: access width codes,
// sequencer states, IO window defaults and small combinational helpers.
package mem_access_ctrl_pkg;

   // Access width encoding as presented by the EX/MEM pipeline register.
   localparam logic [1:0] W_BYTE    = 2'b00;
   localparam logic [1:0] W_HALF    = 2'b01;
   localparam logic [1:0] W_ILLEGAL = 2'b10;
   localparam logic [1:0] W_WORD    = 2'b11;

   // First byte address of the memory-mapped IO window (runs to the top of
   // the 32-bit space) and the default ack wait budget.
   localparam logic [31:0] IO_BASE_DEFAULT    = 32'hFFFF_FC00;
   localparam int unsigned IO_TIMEOUT_DEFAULT = 16;

   // Sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_RAM_RD  = 3'd2,
      ST_IO_WAIT = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   // Copy right-aligned store data onto every byte lane it may land on, so
   // the target lane picks its byte without any address-dependent shifting.
   function automatic logic [31:0] replicate_lanes(input logic [1:0]  width,
                                                   input logic [31:0] wdata);
      logic [31:0] rep;
      case (width)
         W_BYTE:  rep = {4{wdata[7:0]}};
         W_HALF:  rep = {2{wdata[15:0]}};
         default: rep = wdata;
      endcase
      return rep;
   endfunction

   // Illegal width code, or a half/word access not on its natural boundary.
   function automatic logic is_misaligned(input logic [1:0] width,
                                          input logic [1:0] addr_lo);
      logic bad;
      case (width)
         W_BYTE:  bad = 1'b0;
         W_HALF:  bad = addr_lo[0];
         W_WORD:  bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational lane select plus sign/zero extension for raw IO read words.
// The IO port returns the full 32-bit word with the addressed byte or half
// still sitting in its lane; this picks it out and right-aligns it.
module mem_access_ctrl_load_extend
   import mem_access_ctrl_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  width_i,
   input  logic        sign_i,
   output logic [31:0] data_o
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Split the word into its four byte lanes.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word_i[8*gi +: 8];
   end

   // Pick the addressed byte / half; half accesses are 2-byte aligned so
   // only offset bit 1 matters for them.
   always_comb begin
      byte_sel = lane[offset_i];
      half_sel = {lane[{offset_i[1], 1'b1}], lane[{offset_i[1], 1'b0}]};
   end

   // Right-align and extend according to width and signedness.
   always_comb begin
      data_o = word_i;
      case (width_i)
         W_BYTE:  data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
         W_HALF:  data_o = {{16{sign_i & half_sel[15]}}, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the EX/MEM stage and a byte-lane data RAM
// with 1-cycle registered read, plus an ack-based IO window with timeout.
// One request is in flight at a time; every accepted request ends in a
// single-cycle response pulse carrying load data or an error flag.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned RAM_ADDR_W = 16,
   parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
   parameter int unsigned IO_TIMEOUT = IO_TIMEOUT_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // request side
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [1:0]            req_width_i,
   input  logic                  req_sign_i,
   input  logic [31:0]           req_addr_i,
   input  logic [31:0]           req_wdata_i,
   // response side
   output logic                  resp_valid_o,
   output logic [31:0]           resp_rdata_o,
   output logic                  resp_err_o,
   // data RAM
   output logic                  ram_wen_o,
   output logic [1:0]            ram_dat_width_o,
   output logic                  ram_sign_o,
   output logic [RAM_ADDR_W-1:0] ram_adr_o,
   output logic [31:0]           ram_dat_o,
   input  logic [31:0]           ram_dat_i,
   input  logic                  ram_bit_error_i,
   // IO port
   output logic                  io_sel_o,
   output logic                  io_we_o,
   output logic [9:0]            io_adr_o,
   output logic [31:0]           io_wdata_o,
   input  logic [31:0]           io_rdata_i,
   input  logic                  io_ack_i
);

   localparam int unsigned      CNT_W    = $clog2(IO_TIMEOUT + 1);
   // Last IO_WAIT cycle index before the wait budget is exhausted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

   state_e                  state_q, state_d;
   logic                    we_q, we_d;
   logic [1:0]              width_q, width_d;
   logic                    sign_q, sign_d;
   logic [RAM_ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    err_q, err_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic                    req_misaligned;
   logic                    req_is_io;
   logic                    req_out_of_range;
   logic                    req_err;
   logic [31:0]             lane_data;
   logic [31:0]             io_load_data;
   logic                    in_issue;
   logic                    in_io_wait;
   logic                    in_resp;

   // Classify the presented request: bad width/alignment, IO window, or an
   // address beyond the RAM that is not in the IO window.
   always_comb begin
      req_misaligned   = is_misaligned(req_width_i, req_addr_i[1:0]);
      req_is_io        = (req_addr_i >= IO_BASE);
      req_out_of_range = !req_is_io && ((req_addr_i >> RAM_ADDR_W) != 32'd0);
      req_err          = req_misaligned || req_out_of_range;
   end

   // Store data replicated onto lanes, shared by the RAM and IO write paths.
   assign lane_data = replicate_lanes(width_q, wdata_q);

   // IO reads come back lane-positioned; extract and extend here.
   mem_access_ctrl_load_extend u_load_extend (
      .word_i   (io_rdata_i),
      .offset_i (addr_q[1:0]),
      .width_i  (width_q),
      .sign_i   (sign_q),
      .data_o   (io_load_data)
   );

   // Next-state and datapath update for the sequencer.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      width_d = width_q;
      sign_d  = sign_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               we_d    = req_we_i;
               width_d = req_width_i;
               sign_d  = req_sign_i;
               addr_d  = req_addr_i[RAM_ADDR_W-1:0];
               wdata_d = req_wdata_i;
               err_d   = req_err;
               rdata_d = '0;
               cnt_d   = '0;
               if (req_err) begin
                  state_d = ST_RESP;
               end else if (req_is_io) begin
                  state_d = ST_IO_WAIT;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            // A store completes here; the RAM flags a lane problem in the
            // same cycle. A load waits one cycle for the registered read.
            if (we_q) begin
               err_d   = ram_bit_error_i;
               state_d = ST_RESP;
            end else begin
               state_d = ST_RAM_RD;
            end
         end

         ST_RAM_RD: begin
            // RAM has already extended the value to 32 bits.
            rdata_d = ram_dat_i;
            state_d = ST_RESP;
         end

         ST_IO_WAIT: begin
            // Ack wins over timeout, including on the final allowed cycle.
            if (io_ack_i) begin
               rdata_d = we_q ? 32'd0 : io_load_data;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and request latch registers; reset abandons any access silently.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         width_q <= W_BYTE;
         sign_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         width_q <= width_d;
         sign_q  <= sign_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output decode: RAM and IO buses are held at zero outside their active
   // state so nothing downstream sees stray toggles.
   always_comb begin
      in_issue   = (state_q == ST_ISSUE);
      in_io_wait = (state_q == ST_IO_WAIT);
      in_resp    = (state_q == ST_RESP);

      req_ready_o     = (state_q == ST_IDLE);

      resp_valid_o    = in_resp;
      resp_err_o      = in_resp & err_q;
      resp_rdata_o    = in_resp ? rdata_q : 32'd0;

      ram_wen_o       = in_issue & we_q;
      ram_dat_width_o = in_issue ? width_q : 2'b00;
      ram_sign_o      = in_issue & sign_q;
      ram_adr_o       = in_issue ? addr_q : '0;
      ram_dat_o       = (in_issue && we_q) ? lane_data : 32'd0;

      io_sel_o        = in_io_wait;
      io_we_o         = in_io_wait & we_q;
      io_adr_o        = in_io_wait ? addr_q[9:0] : 10'd0;
      io_wdata_o      = in_io_wait ? lane_data : 32'd0;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the stimulus computes each expected
// response from the access rules and a byte-array memory model, the monitor
// compares whenever a response pulse appears. RAM and IO are emulated.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_we_i, req_sign_i;
   logic [1:0]  req_width_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        resp_valid_o, resp_err_o;
   logic [31:0] resp_rdata_o;
   logic        ram_wen_o, ram_sign_o, ram_bit_error_i;
   logic [1:0]  ram_dat_width_o;
   logic [15:0] ram_adr_o;
   logic [31:0] ram_dat_o, ram_dat_i;
   logic        io_sel_o, io_we_o, io_ack_i;
   logic [9:0]  io_adr_o;
   logic [31:0] io_wdata_o, io_rdata_i;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_width_i(req_width_i), .req_sign_i(req_sign_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
      .ram_wen_o(ram_wen_o), .ram_dat_width_o(ram_dat_width_o), .ram_sign_o(ram_sign_o),
      .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i),
      .ram_bit_error_i(ram_bit_error_i),
      .io_sel_o(io_sel_o), .io_we_o(io_we_o), .io_adr_o(io_adr_o), .io_wdata_o(io_wdata_o),
      .io_rdata_i(io_rdata_i), .io_ack_i(io_ack_i)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      int          wen;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_resp_cyc = -100;
   bit          chk_en = 1'b0;

   // Current request context, shared with the RAM/IO emulators.
   int          cur_issue_cyc = -1;
   int          cur_delay = 0;
   int          wen_cnt = 0;
   logic        cur_we = 1'b0, cur_sign = 1'b0, cur_bit_err = 1'b0;
   logic [1:0]  cur_width = 2'b00;
   logic [31:0] cur_adr = 32'd0, cur_rep = 32'd0, cur_io_word = 32'd0;

   logic [7:0]  ram_mem   [0:65535];
   logic [7:0]  model_mem [0:65535];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int nbytes(input logic [1:0] w);
      return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] w, input logic s);
      case (w)
         2'b00:   return s ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
         2'b01:   return s ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
         default: return v;
      endcase
   endfunction

   // Each lane l carries data byte (l mod access size).
   function automatic logic [31:0] lanes(input logic [1:0] w, input logic [31:0] d);
      logic [31:0] r;
      for (int l = 0; l < 4; l++) r[8*l +: 8] = d[8*(l % nbytes(w)) +: 8];
      return r;
   endfunction

   // RAM emulator: byte-lane write, 1-cycle registered extended read, and
   // a check that RAM outputs are quiet outside the expected issue cycle.
   logic        rd_pend = 1'b0;
   logic [31:0] rd_val = 32'd0;
   always @(negedge clk) begin : ram_emu
      int a;
      logic [31:0] v;
      ram_dat_i = rd_pend ? rd_val : $urandom;
      rd_pend = 1'b0;
      ram_bit_error_i = ram_wen_o && cur_bit_err;
      if (chk_en) begin
         if (cyc == cur_issue_cyc) begin
            chk("ram_adr", ram_adr_o, cur_adr[15:0]);
            chk("ram_wen", ram_wen_o, cur_we);
            chk("ram_width", ram_dat_width_o, cur_width);
            chk("ram_sign", ram_sign_o, cur_sign);
            if (cur_we) begin
               chk("ram_dat", ram_dat_o, cur_rep);
               if (!cur_bit_err)
                  for (int i = 0; i < nbytes(ram_dat_width_o); i++) begin
                     a = (int'(ram_adr_o) + i) & 65535;
                     ram_mem[a] = ram_dat_o[8*(a % 4) +: 8];
                  end
            end else begin
               v = 32'd0;
               for (int i = 0; i < nbytes(ram_dat_width_o); i++)
                  v[8*i +: 8] = ram_mem[(int'(ram_adr_o) + i) & 65535];
               rd_val = extend(v, ram_dat_width_o, ram_sign_o);
               rd_pend = 1'b1;
            end
         end else begin
            chk("ram_idle", {ram_wen_o, ram_dat_width_o, ram_sign_o, ram_adr_o, ram_dat_o}, 64'd0);
         end
      end
      if (ram_wen_o) wen_cnt++;
   end

   // IO emulator: acks after cur_delay select cycles (never if beyond budget).
   int sel_cnt = 0;
   always @(negedge clk) begin
      if (io_sel_o) begin
         if (sel_cnt == 0) begin
            chk("io_adr", io_adr_o, cur_adr[9:0]);
            chk("io_we", io_we_o, cur_we);
            if (cur_we) chk("io_wdata", io_wdata_o, cur_rep);
         end
         io_ack_i = (sel_cnt == cur_delay);
         io_rdata_i = io_ack_i ? cur_io_word : $urandom;
         sel_cnt++;
      end else begin
         io_ack_i = 1'b0;
         io_rdata_i = $urandom;
         sel_cnt = 0;
      end
   end

   // Monitor: pop and compare on every response pulse.
   always @(negedge clk) begin : mon
      exp_t e;
      if (chk_en && resp_valid_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata_o, e.rdata);
            chk("resp_err", resp_err_o, e.err);
            chk("resp_cycle", cyc, e.cyc);
            chk("ram_wen_count", wen_cnt, e.wen);
            chk("ready_in_resp", req_ready_o, 0);
            $display("resp cyc=%0d rdata=%h err=%0b", cyc, resp_rdata_o, resp_err_o);
         end
         last_resp_cyc = cyc;
      end
   end

   // Present one request, derive its expected outcome, wait for acceptance.
   // Called and returns at a negedge.
   task automatic issue(input logic we, input logic [1:0] w, input logic s,
                        input logic [31:0] a, input logic [31:0] d, input int delay,
                        input logic berr, input logic [31:0] ioword);
      exp_t e;
      int start, n, t, lat;
      logic is_io, bad, oor;
      logic [31:0] v;
      is_io = (a >= 32'hFFFF_FC00);
      bad   = (w == 2'b10) || (w == 2'b01 && a[0]) || (w == 2'b11 && a[1:0] != 2'b00);
      oor   = !is_io && (a > 32'h0000_FFFF);
      e.rdata = 32'd0; e.err = 1'b0; e.wen = 0; lat = 1;
      if (bad || oor) begin
         e.err = 1'b1; lat = 1;
      end else if (is_io) begin
         if (delay < 16) begin
            lat = delay + 2;
            if (!we) e.rdata = extend(ioword >> (8 * a[1:0]), w, s);
         end else begin
            e.err = 1'b1; lat = 17;
         end
      end else if (we) begin
         lat = 2; e.wen = 1; e.err = berr;
      end else begin
         lat = 3; v = 32'd0;
         for (int i = 0; i < nbytes(w); i++) v[8*i +: 8] = model_mem[(a + i) & 32'hFFFF];
         e.rdata = extend(v, w, s);
      end

      req_we_i = we; req_width_i = w; req_sign_i = s; req_addr_i = a; req_wdata_i = d;
      req_valid_i = 1'b1;
      start = cyc; n = 0;
      while (!req_ready_o && n < 100) begin @(negedge clk); n++; end
      if (!req_ready_o) begin
         chk("accept_timeout", 0, 1);
         req_valid_i = 1'b0;
         return;
      end
      t = cyc;
      if (start <= last_resp_cyc) chk("accept_after_resp", t, last_resp_cyc + 1);
      e.cyc = t + lat;
      cur_we = we; cur_width = w; cur_sign = s; cur_adr = a; cur_rep = lanes(w, d);
      cur_bit_err = berr; cur_delay = delay; cur_io_word = ioword;
      cur_issue_cyc = (!bad && !oor && !is_io) ? t + 1 : -1;
      wen_cnt = 0;
      exp_q.push_back(e);
      if (!bad && !oor && !is_io && we && !berr)
         for (int i = 0; i < nbytes(w); i++) model_mem[(a + i) & 32'hFFFF] = d[8*i +: 8];
      $display("req cyc=%0d we=%0b w=%b s=%0b addr=%h wdata=%h -> err=%0b rdata=%h at %0d",
               t, we, w, s, a, d, e.err, e.rdata, e.cyc);
      @(negedge clk);
      req_valid_i = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  w;
      int r;
      for (int i = 0; i < 65536; i++) begin ram_mem[i] = 8'h00; model_mem[i] = 8'h00; end
      rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_width_i = 2'b00;
      req_sign_i = 1'b0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
      ram_dat_i = 32'd0; ram_bit_error_i = 1'b0; io_rdata_i = 32'd0; io_ack_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready_o, 1);
      chk("rst_resp", {resp_valid_o, resp_err_o, resp_rdata_o}, 0);
      chk("rst_ram", {ram_wen_o, ram_dat_width_o, ram_sign_o, ram_adr_o, ram_dat_o}, 0);
      chk("rst_io", {io_sel_o, io_we_o, io_adr_o, io_wdata_o}, 0);
      rst_i = 1'b0;
      chk_en = 1'b1;

      // directed cases
      issue(1, 2'b00, 0, 32'h0000_0001, 32'h0000_00A5, 0, 0, 0);
      issue(1, 2'b11, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0);
      issue(0, 2'b11, 0, 32'h0000_0010, 32'h0, 0, 0, 0);
      issue(0, 2'b00, 1, 32'h0000_0001, 32'h0, 0, 0, 0);
      issue(0, 2'b01, 0, 32'h0000_0003, 32'h0, 0, 0, 0);
      issue(1, 2'b10, 0, 32'h0000_0004, 32'h1234_5678, 0, 0, 0);
      issue(1, 2'b11, 0, 32'h0001_0000, 32'h1111_1111, 0, 0, 0);
      issue(0, 2'b00, 1, 32'hFFFF_FC02, 32'h0, 3, 0, 32'h0080_0000);
      issue(1, 2'b01, 0, 32'hFFFF_FC04, 32'h0000_1234, 16, 0, 0);
      issue(0, 2'b01, 1, 32'hFFFF_FC06, 32'h0, 15, 0, 32'h8001_0000);
      issue(1, 2'b00, 0, 32'h0000_0020, 32'h0000_0077, 0, 1, 0);
      issue(0, 2'b00, 0, 32'h0000_0020, 32'h0, 0, 0, 0);

      // reset while waiting on IO: access dropped, no response
      issue(0, 2'b11, 0, 32'hFFFF_FC10, 32'h0, 40, 0, 0);
      repeat (4) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("rst_mid_io_sel", io_sel_o, 0);
      chk("rst_mid_ready", req_ready_o, 1);
      chk("rst_mid_resp", resp_valid_o, 0);
      exp_q.delete();
      repeat (20) @(negedge clk);

      // randomized traffic
      for (int k = 0; k < 250; k++) begin
         r = $urandom_range(0, 9);
         if (r <= 5)      a = ($urandom_range(0, 7) == 0) ? 32'hFFC0 + $urandom_range(0, 63)
                                                           : $urandom_range(0, 63);
         else if (r <= 7) a = 32'hFFFF_FC00 + $urandom_range(0, 1023);
         else if (r == 8) a = 32'h0001_0000 + $urandom_range(0, 1 << 20);
         else             a = 32'hFFFF_FC00 - $urandom_range(1, 64);
         r = $urandom_range(0, 9);
         w = (r == 0) ? 2'b10 : (r <= 3) ? 2'b00 : (r <= 6) ? 2'b01 : 2'b11;
         if ($urandom_range(0, 3) != 0) begin
            if (w == 2'b01) a[0] = 1'b0;
            if (w == 2'b11) a[1:0] = 2'b00;
         end
         r = $urandom_range(0, 1);
         issue(r[0], w, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 17),
               r[0] && ($urandom_range(0, 9) == 0), $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer between the EX/MEM pipeline register and the byte-lane data memory (4×8 BRAM, 16-bit byte address, 1-cycle registered read).
- Accepts one request at a time and checks alignment and range.
- Replicates store data onto byte lanes so each BRAM lane sees its byte.
- Routes IO-region accesses to an ack-based IO port with timeout.
- Returns a one-cycle response pulse with load data or an error flag.

Parameters:
- RAM_ADDR_W, 16, byte-address width of data RAM; addresses at or above 2**RAM_ADDR_W that are outside the IO region are out-of-range.
- IO_BASE, 32'hFFFF_FC00, first IO byte address; the IO region runs to 32'hFFFF_FFFF.
- IO_TIMEOUT, 16, cycles to wait for io_ack_i before an error response.

Ports:
- clk_i  in  1  clock, shared with the data RAM.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present; held until accepted.
- req_ready_o  out  1  block idle and can accept.
- req_we_i  in  1  1=store, 0=load.
- req_width_i  in  2  00 byte, 01 half, 11 word, 10 illegal.
- req_sign_i  in  1  sign-extend loads.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  32  extended load data; 0 for stores and errors.
- resp_err_o  out  1  misaligned, illegal width, out-of-range, RAM bit error, or IO timeout.
- ram_wen_o  out  1  RAM write enable.
- ram_dat_width_o  out  2  width to RAM.
- ram_sign_o  out  1  sign to RAM.
- ram_adr_o  out  16  RAM byte address.
- ram_dat_o  out  32  lane-replicated store data.
- ram_dat_i  in  32  RAM read data, already extended by the RAM.
- ram_bit_error_i  in  1  RAM-side alignment error.
- io_sel_o  out  1  IO access active.
- io_we_o  out  1  IO write.
- io_adr_o  out  10  IO offset, req_addr_i[9:0].
- io_wdata_o  out  32  lane-replicated store data.
- io_rdata_i  in  32  raw IO word, lane-positioned.
- io_ack_i  in  1  IO completes this cycle.

Behaviour:
- Reset: state IDLE, all outputs 0 except req_ready_o=1.
  - Reset mid-operation aborts the access with no response; an issued RAM write is not undone.
- State machine: IDLE, ISSUE, RAM_RD, IO_WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch all request fields and classify:
    - Error if width=10, half with addr[0]=1, word with addr[1:0]!=0, or out-of-range; go to RESP with error.
    - IO if addr>=IO_BASE; go to IO_WAIT.
    - Otherwise go to ISSUE.
- ISSUE (one cycle):
  - Drive ram_adr_o, width and sign from the latch.
  - Store: ram_wen_o=1 for exactly this cycle; error if ram_bit_error_i; go to RESP.
  - Load: ram_wen_o=0; go to RAM_RD.
- RAM_RD: capture ram_dat_i into resp_rdata; go to RESP.
- IO_WAIT:
  - io_sel_o=1 and io_we_o, io_adr_o, io_wdata_o held stable.
  - Counter starts at 0 on entry.
  - On io_ack_i: for loads, extract the lane by addr[1:0]/width and extend by sign; go to RESP.
  - After IO_TIMEOUT cycles with no ack: error; go to RESP.
  - An ack in the same cycle as the counter reaching IO_TIMEOUT counts as success.
- RESP: resp_valid_o=1 for one cycle; go to IDLE.
  - A new request is accepted on the following cycle, not in RESP.
- Lane replication:
  - byte {4{wdata[7:0]}}
  - half {2{wdata[15:0]}}
  - word unchanged
- Latency from the acceptance cycle T:
  - RAM store: response at T+2.
  - RAM load: response at T+3.
  - Error: response at T+1.
  - IO: response one cycle after ack.
- Invariants: no RAM output toggles outside ISSUE; ram_wen_o is never asserted for an errored request.

Decomposition:
- Shared package holds:
  - width codes (W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b11)
  - state enum
  - IO_BASE default
- One sub-module, load_extend: combinational lane select plus sign/zero extension, used on the IO read path.

Test Plan:
- Store byte addr 0x0001, wdata 0x000000A5 -> ISSUE: ram_dat_o=0xA5A5A5A5, ram_wen_o 1 cycle, ram_adr_o=0x0001; resp at T+2, err=0.
- Load word addr 0x0010 with RAM returning 0xDEADBEEF -> resp_rdata_o=0xDEADBEEF at T+3.
- Load half addr 0x0003 -> resp_err_o=1 at T+1, ram_wen_o never asserted; width 10 likewise errors.
- IO load byte, signed, addr 0xFFFFFC02, io_rdata_i=0x00800000, ack after 3 cycles -> io_adr_o=0x002, resp_rdata_o=0xFFFFFF80.
- IO store, no ack -> io_sel_o held exactly IO_TIMEOUT=16 cycles, then resp_err_o=1; next request accepted the cycle after RESP.
- rst_i asserted during IO_WAIT -> next cycle io_sel_o=0, req_ready_o=1, no resp_valid_o pulse.
